// File: rtl/word_result_buffer.sv
// Result buffer behind the 8-bit word-arithmetic stage: a small first-word-fall-through FIFO
// between two valid/ready interfaces, plus running count/sum/max statistics over accepted words.
module word_result_buffer #(
    parameter int DEPTH = 4,
    parameter int SUM_W = 16,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [7:0]                 in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [7:0]                 out_data,
    input  logic                       out_ready,
    input  logic                       clear,
    output logic [CNT_W-1:0]           stat_count,
    output logic [SUM_W-1:0]           stat_sum,
    output logic [7:0]                 stat_max,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {
        S_EMPTY   = 2'd0,
        S_PARTIAL = 2'd1,
        S_FULL    = 2'd2
    } state_e;

    logic [7:0]       mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic [LW-1:0]    level_d;
    state_e           state_q;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [SUM_W-1:0] sum_q;
    logic [SUM_W-1:0] sum_d;
    logic [7:0]       max_q;
    logic [7:0]       max_d;

    logic             push;
    logic             pop;

    // A full FIFO still accepts when the consumer frees the head slot on the same edge.
    assign in_ready  = (level_q < LW'(DEPTH)) || out_ready;
    assign out_valid = (state_q != S_EMPTY);
    assign out_data  = mem_q[rd_ptr_q];
    assign level     = level_q;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    always_comb begin
        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !push) begin
            level_d = level_q - LW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            level_q <= level_d;
        end
    end

    // Occupancy class; push+pop together never changes it, and in EMPTY pop cannot fire.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (push) begin
                        state_q <= (DEPTH == 1) ? S_FULL : S_PARTIAL;
                    end
                end
                S_PARTIAL: begin
                    if (push && !pop && level_q == LW'(DEPTH - 1)) begin
                        state_q <= S_FULL;
                    end else if (pop && !push && level_q == LW'(1)) begin
                        state_q <= S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (pop && !push) begin
                        state_q <= (DEPTH == 1) ? S_EMPTY : S_PARTIAL;
                    end
                end
                default: state_q <= S_EMPTY;
            endcase
        end
    end

    always_comb begin
        count_d = count_q;
        sum_d   = sum_q;
        max_d   = max_q;
        if (clear) begin
            count_d = '0;
            sum_d   = '0;
            max_d   = '0;
        end else if (push) begin
            if (count_q != {CNT_W{1'b1}}) begin
                count_d = count_q + CNT_W'(1);
            end
            sum_d = sum_q + SUM_W'(in_data);
            if (in_data > max_q) begin
                max_d = in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            sum_q   <= '0;
            max_q   <= '0;
        end else begin
            count_q <= count_d;
            sum_q   <= sum_d;
            max_q   <= max_d;
        end
    end

    assign stat_count = count_q;
    assign stat_sum   = sum_q;
    assign stat_max   = max_q;

endmodule
